pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the iCE40 PLL (12 MHz ref -> 201 MHz core) at power-up and after faults.
//  - Holds the PLL in reset, waits for a filtered LOCK and only then releases the pulse-logic reset.
//  - On lock loss, re-sequences the PLL.
//  - Runs on the reference clock, because PLLOUT is not trusted until locked.
//  - Sits between the board reset input, the PLL wrapper (RESETB/LOCK) and the pulse-generation core.
// PARAMETERS
//  RESET_HOLD    16      cycles PLL_RESETB held low per attempt (>=1)
//  LOCK_FILTER   64      consecutive synchronised-LOCK-high cycles required (>=1)
//  RELEASE_DELAY 8       cycles from filtered lock to SYS_RESETN release (>=1)
//  LOCK_TIMEOUT  120000  cycles allowed in WAIT_LOCK+FILTER per attempt (10 ms @ 12 MHz)
//  MAX_RETRY     7       failed attempts before FAULT (1..15)
// PORTS
//  REFERENCECLK  in   1  12 MHz reference clock; all logic is on its rising edge
//  RESET         in   1  asynchronous, active-low reset
//  PLL_LOCK      in   1  PLL LOCK; asynchronous, passed through a 2-flop synchroniser -> lock_s
//  RELOCK_REQ    in   1  one-cycle pulse: force re-sequence (RUN) or clear fault (FAULT)
//  PLL_RESETB    out  1  to PLL RESETB; active low
//  SYS_RESETN    out  1  active-low reset for the pulse core; high only in RUN
//  READY         out  1  high only in RUN
//  FAULT         out  1  high only in FAULT
//  RETRY_COUNT   out  4  failed attempts in the current sequence
//  LOSS_COUNT    out  8  lock-loss events seen in RUN; saturates at 255
//  STATE         out  3  HOLD=0, WAIT_LOCK=1, FILTER=2, RELEASE=3, RUN=4, FAULT=5
// BEHAVIOUR
//  Reset (async, RESET=0):
//   - Clears the synchroniser, all counters and RETRY_COUNT/LOSS_COUNT.
//   - STATE=HOLD; PLL_RESETB=0, SYS_RESETN=0, READY=0, FAULT=0.
//   - Mid-operation reset takes effect immediately, without waiting for a clock edge.
//  Outputs: registered, decoded from the next state, so they change on the edge that enters a state.
//  PLL_RESETB: 0 in HOLD and FAULT, 1 otherwise.
//  HOLD:
//   - Phase counter runs 0..RESET_HOLD-1, then WAIT_LOCK.
//   - Phase counter and timeout timer are zeroed on entry.
//  WAIT_LOCK:
//   - lock_s=1 -> FILTER; phase counter cleared.
//   - Timeout timer increments each cycle in WAIT_LOCK and FILTER.
//  FILTER:
//   - Phase counter increments while lock_s=1.
//   - lock_s=0 -> WAIT_LOCK; the timeout timer is NOT cleared.
//   - Counter==LOCK_FILTER-1 with lock_s=1 -> RELEASE.
//  Timeout (WAIT_LOCK/FILTER, timer==LOCK_TIMEOUT-1), priority over the lock transition:
//   - RETRY_COUNT+1.
//   - If the new value == MAX_RETRY -> FAULT, else -> HOLD.
//  RELEASE:
//   - Counts RELEASE_DELAY cycles, then RUN; RETRY_COUNT cleared on entering RUN.
//   - lock_s=0 -> HOLD. Not a retry; no count changes.
//  RUN:
//   - lock_s=0 -> HOLD, LOSS_COUNT+1 (saturating).
//   - RELOCK_REQ -> HOLD.
//   - Both in the same cycle -> HOLD, LOSS_COUNT+1 once.
//  FAULT:
//   - Stays until RELOCK_REQ -> HOLD with RETRY_COUNT cleared.
//   - LOCK is ignored.
//  RELOCK_REQ in HOLD/WAIT_LOCK/FILTER/RELEASE: ignored.
//  Latency: number the first edge that samples PLL_LOCK=1 as edge 1, during WAIT_LOCK with a stable lock.
//   - STATE=FILTER after edge 3.
//   - READY=1, SYS_RESETN=1 after edge LOCK_FILTER+RELEASE_DELAY+3.
//   - After a lock drop in RUN: SYS_RESETN=0 on the 3rd edge sampling PLL_LOCK=0 (2 sync + 1).
//  Widths: phase counter ceil(log2(max(RESET_HOLD,LOCK_FILTER,RELEASE_DELAY)+1)); timer ceil(log2(LOCK_TIMEOUT+1)).
// TESTING  (RESET_HOLD=3, LOCK_FILTER=4, RELEASE_DELAY=2, LOCK_TIMEOUT=50, MAX_RETRY=2)
//  1. Release RESET; PLL_LOCK=1 from cycle 10.
//     -> PLL_RESETB rises 3 edges after reset release.
//     -> READY/SYS_RESETN rise exactly 9 edges after PLL_LOCK is first sampled high.
//  2. PLL_LOCK held 0.
//     -> Two timeouts, with RETRY_COUNT 1 then 2; then FAULT=1, PLL_RESETB=0.
//     -> RELOCK_REQ pulse -> HOLD, RETRY_COUNT=0.
//  3. PLL_LOCK glitches low for 1 cycle during FILTER.
//     -> Back to WAIT_LOCK; the filter restarts.
//     -> The timeout still counts from the original WAIT_LOCK entry.
//  4. In RUN, drop PLL_LOCK.
//     -> SYS_RESETN=0 on the 3rd edge; LOSS_COUNT=1.
//     -> Full re-sequence back to RUN when lock returns.
//  5. In RUN, RELOCK_REQ and lock loss in the same cycle.
//     -> HOLD, LOSS_COUNT increments by exactly 1.
//  6. Assert RESET mid-FILTER and mid-RUN.
//     -> All outputs at reset values with no clock edge; counters cleared.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer running on the reference clock
// Holds the PLL in reset, filters LOCK, then releases the core reset; re-sequences on lock loss.
module pll_lock_sequencer #(
    parameter int RESET_HOLD    = 16,
    parameter int LOCK_FILTER   = 64,
    parameter int RELEASE_DELAY = 8,
    parameter int LOCK_TIMEOUT  = 120000,
    parameter int MAX_RETRY     = 7
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       RELOCK_REQ,
    output logic       PLL_RESETB,
    output logic       SYS_RESETN,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT,
    output logic [2:0] STATE
);

    localparam int PMAX_A = (RESET_HOLD > LOCK_FILTER) ? RESET_HOLD : LOCK_FILTER;
    localparam int PMAX   = (PMAX_A > RELEASE_DELAY) ? PMAX_A : RELEASE_DELAY;
    localparam int PW     = $clog2(PMAX + 1);
    localparam int TW     = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PW-1:0] HOLD_LAST    = PW'(RESET_HOLD - 1);
    localparam logic [PW-1:0] FILTER_LAST  = PW'(LOCK_FILTER - 1);
    localparam logic [PW-1:0] RELEASE_LAST = PW'(RELEASE_DELAY - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] phase, phase_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    retry, retry_d;
    logic [7:0]    loss, loss_d;
    logic          sync1, lock_s;
    logic          pll_resetb_q, sys_resetn_q, fault_q;
    logic [3:0]    retry_inc;

    assign retry_inc = retry + 4'd1;

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            sync1        <= 1'b0;
            lock_s       <= 1'b0;
            state        <= S_HOLD;
            phase        <= '0;
            timer        <= '0;
            retry        <= '0;
            loss         <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync1        <= PLL_LOCK;
            lock_s       <= sync1;
            state        <= state_d;
            phase        <= phase_d;
            timer        <= timer_d;
            retry        <= retry_d;
            loss         <= loss_d;
            pll_resetb_q <= !(state_d == S_HOLD || state_d == S_FAULT);
            sys_resetn_q <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        timer_d = timer;
        retry_d = retry;
        loss_d  = loss;
        case (state)
            S_HOLD: begin
                timer_d = '0;
                if (phase == HOLD_LAST) begin
                    state_d = S_WAIT_LOCK;
                    phase_d = '0;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            S_WAIT_LOCK, S_FILTER: begin
                timer_d = timer + 1'b1;
                // Timeout wins over any lock transition in the same cycle
                if (timer == TIMER_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_HOLD;
                    phase_d = '0;
                    timer_d = '0;
                end else if (state == S_WAIT_LOCK) begin
                    if (lock_s) begin
                        state_d = S_FILTER;
                        phase_d = '0;
                    end
                end else if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    phase_d = '0;
                end else if (phase == FILTER_LAST) begin
                    state_d = S_RELEASE;
                    phase_d = '0;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end else if (phase == RELEASE_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    retry_d = '0;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s || RELOCK_REQ) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end
                if (!lock_s && loss != 8'hFF) begin
                    loss_d = loss + 8'd1;
                end
            end
            S_FAULT: begin
                if (RELOCK_REQ) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
                phase_d = '0;
            end
        endcase
    end

    assign PLL_RESETB  = pll_resetb_q;
    assign SYS_RESETN  = sys_resetn_q;
    assign READY       = sys_resetn_q;
    assign FAULT       = fault_q;
    assign RETRY_COUNT = retry;
    assign LOSS_COUNT  = loss;
    assign STATE       = state;

endmodule
